// File: rtl/register_file_param_if.sv
// Register file access bundle: one byte-masked write port, two registered
// read ports with valid flags, and the bulk-clear request/busy pair.
interface register_file_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                      WriteEn;
    logic [ADDR_WIDTH-1:0]     WriteAddress;
    logic [DATA_WIDTH-1:0]     WriteData;
    logic [DATA_WIDTH/8-1:0]   WriteByteEn;
    logic                      ReadEn1;
    logic [ADDR_WIDTH-1:0]     ReadAddress1;
    logic [DATA_WIDTH-1:0]     ReadData1;
    logic                      ReadValid1;
    logic                      ReadEn2;
    logic [ADDR_WIDTH-1:0]     ReadAddress2;
    logic [DATA_WIDTH-1:0]     ReadData2;
    logic                      ReadValid2;
    logic                      Clear;
    logic                      Busy;

    modport master (
        output WriteEn, WriteAddress, WriteData, WriteByteEn,
        output ReadEn1, ReadAddress1, ReadEn2, ReadAddress2, Clear,
        input  ReadData1, ReadValid1, ReadData2, ReadValid2, Busy
    );

    modport slave (
        input  WriteEn, WriteAddress, WriteData, WriteByteEn,
        input  ReadEn1, ReadAddress1, ReadEn2, ReadAddress2, Clear,
        output ReadData1, ReadValid1, ReadData2, ReadValid2, Busy
    );
endinterface

// File: rtl/register_file_param.sv
// Parametrised 2R/1W register file with byte enables, write-first bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle bulk clear.
module register_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    register_file_param_if.slave  bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_data1;
    logic [DATA_WIDTH-1:0]   r_rd_data2;
    logic                    r_rd_valid1;
    logic                    r_rd_valid2;

    logic                    w_wr_in_range;
    logic                    w_wr_ok;
    logic [DATA_WIDTH-1:0]   w_wr_merged;
    logic [DATA_WIDTH-1:0]   w_rd_val1;
    logic [DATA_WIDTH-1:0]   w_rd_val2;

    function automatic logic is_zero_entry(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign w_wr_in_range = 32'(bus.WriteAddress) < DEPTH;
    assign w_wr_ok = bus.WriteEn && !r_busy && w_wr_in_range
                     && !is_zero_entry(bus.WriteAddress);

    // Merge of the new bytes over the current entry; reused as the bypass value.
    always_comb begin
        // NOTE: assign a default first so every path drives the variable and no latch is inferred.
        w_wr_merged = w_wr_in_range ? r_mem[bus.WriteAddress] : '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (bus.WriteByteEn[b]) w_wr_merged[8*b +: 8] = bus.WriteData[8*b +: 8];
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] addr);
        if (r_busy || !(32'(addr) < DEPTH) || is_zero_entry(addr)) return '0;
        if (w_wr_ok && addr == bus.WriteAddress) return w_wr_merged;
        return r_mem[addr];
    endfunction

    always_comb begin
        w_rd_val1 = read_value(bus.ReadAddress1);
        w_rd_val2 = read_value(bus.ReadAddress2);
    end

    // NOTE: storage is a reset flop array, since reset must zero every entry; it will not map to RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy && r_clr_cnt == ADDR_WIDTH'(i)) begin
                    r_mem[i] <= '0;
                end else if (w_wr_ok && bus.WriteAddress == ADDR_WIDTH'(i)) begin
                    r_mem[i] <= w_wr_merged;
                end
            end
        end
    end

    // Clear sequencer: one entry per edge, Clear ignored while already clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Clear) begin
                        r_state   <= S_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_clr_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data1  <= '0;
            r_rd_data2  <= '0;
            r_rd_valid1 <= 1'b0;
            r_rd_valid2 <= 1'b0;
        end else begin
            r_rd_valid1 <= bus.ReadEn1;
            r_rd_valid2 <= bus.ReadEn2;
            if (bus.ReadEn1) r_rd_data1 <= w_rd_val1;
            if (bus.ReadEn2) r_rd_data2 <= w_rd_val2;
        end
    end

    assign bus.ReadData1  = r_rd_data1;
    assign bus.ReadData2  = r_rd_data2;
    assign bus.ReadValid1 = r_rd_valid1;
    assign bus.ReadValid2 = r_rd_valid2;
    assign bus.Busy       = r_busy;
endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the team's 32x32 two-read/one-write register file. It generalises data width and depth, adds per-byte write enables, and registers its read ports with valid flags. It also adds write-first bypass, an optional hardwired-zero entry 0, and a multi-cycle bulk clear sequencer. It sits between the decode stage, which drives read addresses, and writeback, which drives the write port, in the datapath.

Parameters:
DATA_WIDTH, 32, bits per entry; must be a multiple of 8
ADDR_WIDTH, 5, address bits per port
DEPTH, 32, number of implemented entries; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
WriteEn  input  1  write request this cycle
WriteAddress  input  ADDR_WIDTH  write target
WriteData  input  DATA_WIDTH  write value
WriteByteEn  input  DATA_WIDTH/8  byte lane mask; bit i gates WriteData[8i+7:8i]
ReadEn1  input  1  read request, port 1
ReadAddress1  input  ADDR_WIDTH  read address, port 1
ReadData1  output  DATA_WIDTH  registered read data, port 1
ReadValid1  output  1  ReadData1 is valid this cycle
ReadEn2  input  1  read request, port 2
ReadAddress2  input  ADDR_WIDTH  read address, port 2
ReadData2  output  DATA_WIDTH  registered read data, port 2
ReadValid2  output  1  ReadData2 is valid this cycle
Clear  input  1  single-cycle request to zero all entries
Busy  output  1  clear sequence in progress

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all DEPTH entries go to 0
  - ReadData1/2 = 0, ReadValid1/2 = 0, Busy = 0
  - FSM goes to IDLE; clear counter goes to 0
  - this also applies when reset is asserted mid-clear or mid-access
- Write:
  - On the rising edge with WriteEn=1, Busy=0 and an in-range address, each byte lane i with WriteByteEn[i]=1 is updated from WriteData. Other lanes hold their value.
  - WriteByteEn = 0 means no change.
  - A write with WriteAddress >= DEPTH is dropped.
  - A write to address 0 is dropped when ZERO_REG=1.
- Read (per port, independent):
  - Latency is 1 cycle. ReadEn sampled on edge N gives ReadValid=1 and ReadData during cycle N+1.
  - ReadEn=0 gives ReadValid=0 the next cycle, and ReadData holds its last value.
  - Address >= DEPTH returns 0 with ReadValid=1.
  - Address 0 with ZERO_REG=1 returns 0.
- Bypass (write-first):
  - Applies when the same edge has an accepted write and a read of the same address.
  - ReadData is the post-write merged value: new bytes where WriteByteEn is set, old bytes elsewhere.
  - Both ports may bypass simultaneously.
  - A dropped write does not bypass.
- Both read ports may read the same address in the same cycle; both return identical data.
- Clear FSM, two states:
  - IDLE: Busy=0. Clear=1 moves the FSM to CLEAR on the next edge with counter=0.
  - CLEAR: Busy=1. Each edge zeroes entry[counter] and increments the counter. When counter=DEPTH-1, that entry is zeroed and the FSM returns to IDLE.
  - Busy is therefore high for exactly DEPTH cycles.
  - Clear while in CLEAR is ignored and does not restart the sequence.
  - During CLEAR, writes are dropped.
  - During CLEAR, reads are accepted (ReadValid asserted as normal) but always return 0.
  - A write on the same edge that Clear is sampled in IDLE is performed; the clear sequence then zeroes that entry.
- Storage uses no arithmetic beyond the clear counter, which is ADDR_WIDTH bits wide and wraps only through the DEPTH-1 terminal check.

Test Plan:
1. Reset defaults: hold rst_n=0, then release. Read addresses 0, 1 and 31 on both ports -> each returns 0 with ReadValid=1 one cycle after ReadEn. Busy=0 throughout.
2. Basic write/read: write 10 to addr 0 and 20 to addr 1, all bytes enabled, with ZERO_REG=1.
   -> Port1 reading addr 0 returns 0.
   -> Port2 reading addr 1 returns 20, one cycle after ReadEn.
   -> With ZERO_REG=0, addr 0 returns 10.
3. Byte enables and bypass: write 0xAABBCCDD to addr 5. Then, in the same cycle, write 0x11223344 to addr 5 with WriteByteEn=4'b0101 and read addr 5 on both ports.
   -> Both ports return 0xAA22CC44 next cycle.
   -> A later read also returns 0xAA22CC44.
4. Out-of-range: set DEPTH=20, write 0x55 to addr 25, then read addr 25 -> returns 0 with ReadValid=1. Entries 0-19 are unchanged.
5. Clear sequence: fill addr 1..31 with value=addr, then pulse Clear for 1 cycle.
   -> Busy is high for exactly 32 cycles.
   -> A write to addr 3 mid-clear is dropped.
   -> Reads during Busy return 0.
   -> After Busy falls, every address reads 0.
   -> A second Clear pulse mid-sequence does not extend Busy.
6. Reset mid-clear: assert rst_n=0 during cycle 10 of CLEAR -> Busy=0, ReadValid=0 and ReadData=0 immediately, without waiting for clk. After release, all entries read 0 and the FSM accepts a new Clear.
